twowire_host_engine: RTL and testbench

- Probe-side (host) command engine for Two-Wire Debug; drives the opposite end of the serial link that the DTM core terminates.
- Accepts one command at a time from host logic.
- Serialises start bit, command, parity and write payload onto DIO. For reads, turns the bus around, captures payload and parity, and returns read data to the host.
- Bit pacing comes from an external DCK divider strobe.

---
 rtl/twowire_host_engine_pkg.sv | 41 ++++
 rtl/twowire_host_engine_if.sv | 22 ++
 rtl/twowire_host_shifter.sv | 48 ++++
 rtl/twowire_host_engine.sv | 130 +++++++++++++
 tb/tb_twowire_host_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/twowire_host_engine_pkg.sv
// rtl/twowire_host_engine_pkg.sv - Two-Wire Debug command codes, FSM states and payload sizing
package twowire_host_engine_pkg;

    localparam logic [15:0] TWD_VERSION = 16'h0100;

    typedef enum logic [3:0] {
        CMD_DISCONNECT = 4'd0,
        CMD_R_IDCODE   = 4'd1,
        CMD_R_CSR      = 4'd2,
        CMD_W_CSR      = 4'd3,
        CMD_R_ADDR     = 4'd4,
        CMD_W_ADDR     = 4'd5,
        CMD_R_DATA     = 4'd7,
        CMD_R_BUFF     = 4'd8,
        CMD_W_DATA     = 4'd9
    } twd_cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_CMD, ST_CPAR, ST_WDATA, ST_WPAR,
        ST_TURN1, ST_RDATA, ST_RPAR, ST_TURN2, ST_DONE
    } twd_state_e;

    function automatic logic [5:0] twd_addr_bits(input int unsigned asize);
        return 6'(8 * (asize + 1));
    endfunction

    // Undefined codes fall through to zero length and frame like DISCONNECT.
    function automatic logic [5:0] twd_payload_len(input logic [3:0] cmd, input int unsigned asize);
        case (cmd)
            CMD_R_ADDR, CMD_W_ADDR:                   return twd_addr_bits(asize);
            CMD_R_IDCODE, CMD_R_CSR, CMD_W_CSR,
            CMD_R_DATA, CMD_R_BUFF, CMD_W_DATA:       return 6'd32;
            default:                                  return 6'd0;
        endcase
    endfunction

    function automatic logic twd_is_write(input logic [3:0] cmd);
        return (cmd == CMD_W_CSR) || (cmd == CMD_W_ADDR) || (cmd == CMD_W_DATA);
    endfunction

endpackage

// File: rtl/twowire_host_engine_if.sv
// rtl/twowire_host_engine_if.sv - host request/response bundle for the Two-Wire host engine
interface twowire_host_engine_if #(
    parameter int W_CMD = 4
);
    logic             req_vld;
    logic             req_rdy;
    logic [W_CMD-1:0] req_cmd;
    logic [31:0]      req_wdata;
    logic             rsp_vld;
    logic [31:0]      rsp_rdata;
    logic             rsp_parity_err;

    modport master (
        output req_vld, req_cmd, req_wdata,
        input  req_rdy, rsp_vld, rsp_rdata, rsp_parity_err
    );

    modport slave (
        input  req_vld, req_cmd, req_wdata,
        output req_rdy, rsp_vld, rsp_rdata, rsp_parity_err
    );
endinterface

// File: rtl/twowire_host_shifter.sv
// rtl/twowire_host_shifter.sv - payload register, LSB-byte-first/MSB-bit-first indexing, bit counter, running parity
module twowire_host_shifter (
    input  logic        clk,
    input  logic        drst_n,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic [5:0]  i_nbits,
    input  logic        i_shift_out,
    input  logic        i_shift_in,
    input  logic        i_din,
    output logic        o_bit,
    output logic        o_last,
    output logic        o_parity,
    output logic [31:0] o_data
);
    logic [31:0] r_data;
    logic [5:0]  r_cnt;
    logic        r_par;
    logic [1:0]  w_byte;
    logic [4:0]  w_idx;

    // Counter runs N-1..0; low bits give the MSB-first bit, high bits the byte walking up from byte 0.
    assign w_byte   = i_nbits[4:3] - 2'd1 - r_cnt[4:3];
    assign w_idx    = {w_byte, r_cnt[2:0]};
    assign o_bit    = r_data[w_idx];
    assign o_last   = (r_cnt == 6'd0);
    assign o_parity = r_par;
    assign o_data   = r_data;

    always_ff @(posedge clk or negedge drst_n) begin
        if (!drst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_par  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= i_nbits - 6'd1;
            r_par  <= 1'b0;
        end else if (i_shift_out) begin
            r_par  <= r_par ^ o_bit;
            r_cnt  <= r_cnt - 6'd1;
        end else if (i_shift_in) begin
            r_data[w_idx] <= i_din;
            r_par  <= r_par ^ i_din;
            r_cnt  <= r_cnt - 6'd1;
        end
    end
endmodule

// File: rtl/twowire_host_engine.sv
// rtl/twowire_host_engine.sv - probe-side Two-Wire Debug frame engine: FSM, host handshake, pad enables
module twowire_host_engine
    import twowire_host_engine_pkg::*;
#(
    parameter int W_CMD = 4,
    parameter int ASIZE = 0
) (
    input  logic                   clk,
    input  logic                   drst_n,
    input  logic                   bit_en,
    output logic                   dck_oe,
    output logic                   dio_o,
    output logic                   dio_oe,
    input  logic                   dio_i,
    twowire_host_engine_if.slave   host,
    output logic                   busy
);
    localparam int CW = (W_CMD > 1) ? $clog2(W_CMD) : 1;

    twd_state_e      r_state, w_next;
    logic [W_CMD-1:0] r_cmd;
    logic [CW-1:0]   r_cmd_cnt;
    logic [5:0]      r_nbits;
    logic            r_write;
    logic            r_pmis;
    logic [31:0]     r_rdata;
    logic            r_perr;

    logic            w_accept;
    logic [5:0]      w_req_len;
    logic            w_req_wr;
    logic            w_sh_bit, w_sh_last, w_sh_par;
    logic [31:0]     w_sh_data;

    assign w_accept  = (r_state == ST_IDLE) && host.req_vld;
    assign w_req_len = twd_payload_len(4'(host.req_cmd), ASIZE);
    assign w_req_wr  = twd_is_write(4'(host.req_cmd));

    twowire_host_shifter u_shifter (
        .clk        (clk),
        .drst_n     (drst_n),
        .i_load     (w_accept),
        .i_data     (w_req_wr ? host.req_wdata : 32'd0),
        .i_nbits    (w_accept ? w_req_len : r_nbits),
        .i_shift_out(r_state == ST_WDATA && bit_en),
        .i_shift_in (r_state == ST_RDATA && bit_en),
        .i_din      (dio_i),
        .o_bit      (w_sh_bit),
        .o_last     (w_sh_last),
        .o_parity   (w_sh_par),
        .o_data     (w_sh_data)
    );

    always_ff @(posedge clk or negedge drst_n) begin
        if (!drst_n) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (host.req_vld) w_next = ST_START;
            ST_START: if (bit_en) w_next = ST_CMD;
            ST_CMD:   if (bit_en && r_cmd_cnt == '0) w_next = ST_CPAR;
            ST_CPAR:  if (bit_en) w_next = (r_nbits == 6'd0) ? ST_DONE :
                                           (r_write ? ST_WDATA : ST_TURN1);
            ST_WDATA: if (bit_en && w_sh_last) w_next = ST_WPAR;
            ST_WPAR:  if (bit_en) w_next = ST_DONE;
            ST_TURN1: if (bit_en) w_next = ST_RDATA;
            ST_RDATA: if (bit_en && w_sh_last) w_next = ST_RPAR;
            ST_RPAR:  if (bit_en) w_next = ST_TURN2;
            ST_TURN2: if (bit_en) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dio_o               = 1'b0;
        dio_oe              = 1'b0;
        dck_oe              = 1'b1;
        host.rsp_vld        = 1'b0;
        case (r_state)
            ST_IDLE:  dck_oe = 1'b0;
            ST_DONE:  begin dck_oe = 1'b0; host.rsp_vld = 1'b1; end
            ST_START: begin dio_oe = 1'b1; dio_o = 1'b1;               end
            ST_CMD:   begin dio_oe = 1'b1; dio_o = r_cmd[r_cmd_cnt];   end
            ST_CPAR:  begin dio_oe = 1'b1; dio_o = ^r_cmd;             end
            ST_WDATA: begin dio_oe = 1'b1; dio_o = w_sh_bit;           end
            ST_WPAR:  begin dio_oe = 1'b1; dio_o = w_sh_par;           end
            default:  ;
        endcase
    end

    // Read results are published on entry to DONE so rsp_rdata never moves ahead of rsp_vld.
    always_ff @(posedge clk or negedge drst_n) begin
        if (!drst_n) begin
            r_cmd     <= '0;
            r_cmd_cnt <= '0;
            r_nbits   <= '0;
            r_write   <= 1'b0;
            r_pmis    <= 1'b0;
            r_rdata   <= '0;
            r_perr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd     <= host.req_cmd;
                r_cmd_cnt <= CW'(W_CMD - 1);
                r_nbits   <= w_req_len;
                r_write   <= w_req_wr;
                r_pmis    <= 1'b0;
            end
            if (r_state == ST_CMD && bit_en)
                r_cmd_cnt <= r_cmd_cnt - CW'(1);
            if (r_state == ST_RPAR && bit_en)
                r_pmis <= dio_i ^ w_sh_par;
            if (r_state == ST_TURN2 && bit_en) begin
                r_rdata <= w_sh_data;
                r_perr  <= r_pmis;
            end else if ((r_state == ST_CPAR || r_state == ST_WPAR) && w_next == ST_DONE) begin
                r_perr  <= 1'b0;
            end
        end
    end

    assign host.req_rdy        = (r_state == ST_IDLE);
    assign host.rsp_rdata      = r_rdata;
    assign host.rsp_parity_err = r_perr;
    assign busy                = (r_state != ST_IDLE);
endmodule

// File: tb/tb_twowire_host_engine.sv
// tb/tb_twowire_host_engine.sv - directed scoreboard bench for twowire_host_engine with a target-side DIO model
module tb_twowire_host_engine;
    logic clk = 1'b0;
    logic drst_n;
    logic bit_en;
    logic dck_oe, dio_o, dio_oe, dio_i, busy;

    twowire_host_engine_if #(.W_CMD(4)) host_if ();

    twowire_host_engine #(.W_CMD(4), .ASIZE(0)) dut (
        .clk    (clk),
        .drst_n (drst_n),
        .bit_en (bit_en),
        .dck_oe (dck_oe),
        .dio_o  (dio_o),
        .dio_oe (dio_oe),
        .dio_i  (dio_i),
        .host   (host_if),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        perr;
        int          len;
        logic [63:0] eo;
        logic [63:0] eoe;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          div = 4;
    bit          tgt_rd = 0;
    bit          tgt_flip = 0;
    int          tgt_n = 0;
    logic [31:0] tgt_data = '0;
    logic [31:0] last_rdata = '0;
    bit          in_frame = 0;
    int          nslot = 0;
    logic [63:0] cap_o = '0;
    logic [63:0] cap_oe = '0;

    function automatic int wpos(input int k);
        return (k / 8) * 8 + 7 - (k % 8);
    endfunction

    function automatic logic [31:0] nmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic int tb_len(input logic [3:0] c);
        case (c)
            4'd4, 4'd5:                         return 8;
            4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9: return 32;
            default:                            return 0;
        endcase
    endfunction

    function automatic bit tb_wr(input logic [3:0] c);
        return (c == 4'd3) || (c == 4'd5) || (c == 4'd9);
    endfunction

    function automatic exp_t build(input logic [3:0] c, input logic [31:0] wd, input int n, input bit wr);
        exp_t e;
        logic p;
        e.eo = '0; e.eoe = '0; e.len = 0; e.rdata = '0; e.perr = 1'b0;
        e.eo = {e.eo[62:0], 1'b1}; e.eoe = {e.eoe[62:0], 1'b1}; e.len++;
        for (int i = 3; i >= 0; i--) begin
            e.eo = {e.eo[62:0], c[i]}; e.eoe = {e.eoe[62:0], 1'b1}; e.len++;
        end
        e.eo = {e.eo[62:0], c[0] ^ c[1] ^ c[2] ^ c[3]}; e.eoe = {e.eoe[62:0], 1'b1}; e.len++;
        if (n > 0 && wr) begin
            p = 1'b0;
            for (int k = 0; k < n; k++) begin
                e.eo = {e.eo[62:0], wd[wpos(k)]}; e.eoe = {e.eoe[62:0], 1'b1}; e.len++;
                p = p ^ wd[wpos(k)];
            end
            e.eo = {e.eo[62:0], p}; e.eoe = {e.eoe[62:0], 1'b1}; e.len++;
        end else if (n > 0) begin
            for (int k = 0; k < n + 3; k++) begin
                e.eo = {e.eo[62:0], 1'b0}; e.eoe = {e.eoe[62:0], 1'b0}; e.len++;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Target side: paces DCK, records what the host drives each slot, answers reads.
    initial begin
        int ph;
        ph = 0;
        bit_en = 1'b0;
        dio_i = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1 >= div) ? 0 : ph + 1;
            bit_en = (ph == 0);
            if (!dck_oe) begin
                in_frame = 0;
            end else if (bit_en) begin
                if (!in_frame) begin
                    in_frame = 1; nslot = 0; cap_o = '0; cap_oe = '0;
                end
                if (tgt_rd && nslot >= 7 && nslot < 7 + tgt_n)
                    dio_i = tgt_data[wpos(nslot - 7)];
                else if (tgt_rd && nslot == 7 + tgt_n)
                    dio_i = (^(tgt_data & nmask(tgt_n))) ^ tgt_flip;
                else
                    dio_i = 1'b0;
                cap_o  = {cap_o[62:0], dio_o};
                cap_oe = {cap_oe[62:0], dio_oe};
                nslot++;
            end
        end
    end

    task automatic run(input string tag, input logic [3:0] c, input logic [31:0] wd,
                       input logic [31:0] resp, input bit flip, input bit inject);
        exp_t e, g;
        int   n;
        bit   wr, seen;
        n = tb_len(c);
        wr = tb_wr(c);
        tgt_rd = (n > 0) && !wr;
        tgt_n = n;
        tgt_data = resp;
        tgt_flip = flip;
        e = build(c, wd, n, wr);
        if (tgt_rd) begin
            last_rdata = resp & nmask(n);
            e.perr = flip;
        end
        e.rdata = last_rdata;
        sb.push_back(e);

        host_if.req_vld = 1'b1;
        host_if.req_cmd = c;
        host_if.req_wdata = wd;
        tick();
        host_if.req_vld = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);

        seen = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (host_if.rsp_vld) begin seen = 1; break; end
            host_if.req_vld = (inject && cyc < 8);
            host_if.req_cmd = 4'h0;
            tick();
        end
        host_if.req_vld = 1'b0;
        chk({tag, "_rsp_seen"}, {63'd0, seen}, 64'd1);
        g = sb.pop_front();
        if (seen) begin
            chk({tag, "_rdata"}, {32'd0, host_if.rsp_rdata}, {32'd0, g.rdata});
            chk({tag, "_perr"}, {63'd0, host_if.rsp_parity_err}, {63'd0, g.perr});
            chk({tag, "_slots"}, 64'(nslot), 64'(g.len));
            chk({tag, "_dio"}, cap_o & g.eoe, g.eo);
            chk({tag, "_dio_oe"}, cap_oe, g.eoe);
            chk({tag, "_rdy_low"}, {63'd0, host_if.req_rdy}, 64'd0);
            tick();
            chk({tag, "_vld_pulse"}, {63'd0, host_if.rsp_vld}, 64'd0);
            chk({tag, "_rdy_back"}, {63'd0, host_if.req_rdy}, 64'd1);
        end
    endtask

    initial begin
        bit seen;
        drst_n = 1'b0;
        host_if.req_vld = 1'b0;
        host_if.req_cmd = '0;
        host_if.req_wdata = '0;
        repeat (3) tick();
        chk("rst_dio_o", {63'd0, dio_o}, 64'd0);
        chk("rst_dio_oe", {63'd0, dio_oe}, 64'd0);
        chk("rst_dck_oe", {63'd0, dck_oe}, 64'd0);
        chk("rst_req_rdy", {63'd0, host_if.req_rdy}, 64'd1);
        chk("rst_rsp_vld", {63'd0, host_if.rsp_vld}, 64'd0);
        chk("rst_rdata", {32'd0, host_if.rsp_rdata}, 64'd0);
        chk("rst_perr", {63'd0, host_if.rsp_parity_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        drst_n = 1'b1;
        tick();

        run("wdata", 4'd9, 32'h1234_5678, 32'd0, 0, 0);
        chk("wdata_wire", cap_o, 64'b1_1001_0_01111000_01010110_00110100_00010010_1);

        run("idcode", 4'd1, 32'd0, 32'hDEAD_BEEF, 0, 0);
        chk("idcode_head", cap_o >> 35, 64'b1_0001_1);

        run("idcode_perr", 4'd1, 32'd0, 32'hDEAD_BEEF, 1, 0);

        run("waddr", 4'd5, 32'hFFFF_FFAB, 32'd0, 0, 1);
        chk("waddr_wire", cap_o, 64'b1_0101_0_10101011_1);

        div = 1;
        run("raddr", 4'd4, 32'd0, 32'h1234_565A, 0, 0);
        div = 4;

        run("disc", 4'd0, 32'hFFFF_FFFF, 32'd0, 0, 0);
        run("undef", 4'hF, 32'hFFFF_FFFF, 32'd0, 0, 0);
        chk("undef_wire", cap_o, 64'b1_1111_0);

        tgt_rd = 0;
        host_if.req_vld = 1'b1;
        host_if.req_cmd = 4'd9;
        host_if.req_wdata = 32'hA5A5_A5A5;
        tick();
        host_if.req_vld = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (in_frame && nslot >= 20) begin seen = 1; break; end
            tick();
        end
        chk("abort_reach_slot20", {63'd0, seen}, 64'd1);
        drst_n = 1'b0;
        #1;
        chk("abort_dio_oe", {63'd0, dio_oe}, 64'd0);
        chk("abort_dck_oe", {63'd0, dck_oe}, 64'd0);
        chk("abort_req_rdy", {63'd0, host_if.req_rdy}, 64'd1);
        chk("abort_rdata", {32'd0, host_if.rsp_rdata}, 64'd0);
        last_rdata = '0;
        tick();
        tick();
        drst_n = 1'b1;
        seen = 0;
        repeat (200) begin
            if (host_if.rsp_vld) seen = 1;
            tick();
        end
        chk("abort_no_rsp", {63'd0, seen}, 64'd0);

        run("rcsr", 4'd2, 32'd0, 32'hCAFE_0123, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
